// File: rtl/hex_scan_driver_if.sv
// Display register side of hex_scan_driver: load strobe, value/dp data,
// live display controls, and the registered pin-level outputs.
// Ports: master drives load/value/dp_in/blank_lz/blink_en and reads seg/dp_n/an/frame_done;
//        slave (the driver) is the mirror image.
interface hex_scan_driver_if #(
  parameter int NUM_DIGITS = 8
) ();
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic                      blink_en;
  logic [6:0]                seg;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, blank_lz, blink_en,
    input  seg, dp_n, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_lz, blink_en,
    output seg, dp_n, an, frame_done
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Purpose: time-multiplexed common-anode seven-segment driver for NUM_DIGITS hex digits.
// Latency: outputs registered one cycle behind the digit index; loaded data shows from the next frame.
// Backpressure: none; load is always accepted and back-to-back loads overwrite (last wins).
// Ports: clk, reset (sync, active-high); bus (slave): load/value/dp_in/blank_lz/blink_en in,
//        seg (gfedcba, active-low), dp_n, an (active-low one-hot), frame_done out.
module hex_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               reset,
  hex_scan_driver_if.slave   bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic                  running;
  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fcnt;
  logic                  phase;
  logic [VW-1:0]         shadow_val;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [VW-1:0]         active_val;
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  pending;

  logic [6:0]            seg_r;
  logic                  dp_n_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  frame_done_r;

  logic                  presc_end;
  logic                  frame_wrap;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] nz_from;
  logic                  seen_nz;
  logic                  blank_digit;
  logic                  dark;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign presc_end  = (presc == PW'(SCAN_DIV - 1));
  assign frame_wrap = presc_end && (idx == IW'(NUM_DIGITS - 1));
  assign cur_nib    = active_val[{idx, 2'b00} +: 4];
  assign dark       = bus.blink_en && phase;

  // nz_from[k]: some active nibble at index >= k is nonzero.
  always_comb begin
    nz_from = '0;
    seen_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen_nz    = seen_nz | (|active_val[4*k +: 4]);
      nz_from[k] = seen_nz;
    end
  end

  assign blank_digit = bus.blank_lz && (idx != '0) && !nz_from[idx];

  always_ff @(posedge clk) begin
    // The cycle after reset releases still holds everything cleared, so the
    // first digit enable appears on the second edge after release.
    if (reset || !running) begin
      running      <= ~reset;
      presc        <= '0;
      idx          <= '0;
      fcnt         <= '0;
      phase        <= 1'b0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      active_val   <= '0;
      active_dp    <= '0;
      pending      <= 1'b0;
      seg_r        <= 7'h7F;
      dp_n_r       <= 1'b1;
      an_r         <= '1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_wrap;

      if (presc_end) begin
        presc <= '0;
        idx   <= frame_wrap ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      if (frame_wrap) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end

      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
      end

      // Active data only changes at the frame boundary; a load on the wrap
      // cycle itself bypasses the shadow and lands directly.
      if (frame_wrap) begin
        pending <= 1'b0;
        if (bus.load) begin
          active_val <= bus.value;
          active_dp  <= bus.dp_in;
        end else if (pending) begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      if (dark) begin
        an_r   <= '1;
        seg_r  <= 7'h7F;
        dp_n_r <= 1'b1;
      end else begin
        an_r   <= ~(NUM_DIGITS'(1) << idx);
        seg_r  <= blank_digit ? 7'h7F : glyph(cur_nib);
        dp_n_r <= ~active_dp[idx];
      end
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp_n       = dp_n_r;
  assign bus.an         = an_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_hex_scan_driver.sv
module tb_hex_scan_driver;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int BF = 2;
  localparam int NS = N * S;

  logic clk;
  logic reset;

  hex_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  hex_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] glyph_tab [16];

  // Reference model: position p counts running cycles since the startup edge;
  // digit and frame follow from plain division, frame data from the buffer rules.
  bit         m_started;
  int         m_p;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_shadow_dp, m_disp_dp;
  bit          m_pending;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpn;
  } vec_t;

  vec_t tab [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_shadow    = '0;
    m_disp      = '0;
    m_shadow_dp = '0;
    m_disp_dp   = '0;
    m_pending   = 0;
  endtask

  task automatic step();
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic [3:0]  e_an;
    logic        e_fd;
    bit          s_reset, s_load, s_lz, s_blink;
    logic [15:0] s_val;
    logic [3:0]  s_dp;
    int          pp, d, f, hi;
    @(posedge clk);
    s_reset = reset;
    s_load  = bus.load;
    s_val   = bus.value;
    s_dp    = bus.dp_in;
    s_lz    = bus.blank_lz;
    s_blink = bus.blink_en;
    e_seg = 7'h7F; e_dpn = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    if (s_reset) begin
      m_started = 0;
      model_clear();
    end else if (!m_started) begin
      m_started = 1;
      m_p = 0;
      model_clear();
    end else begin
      pp  = m_p;
      m_p = m_p + 1;
      d = (pp / S) % N;
      f = pp / NS;
      hi = -1;
      for (int k = 0; k < N; k++) if (m_disp[4*k +: 4] != 4'h0) hi = k;
      if (!(s_blink && ((f / BF) % 2 == 1))) begin
        e_an    = 4'hF;
        e_an[d] = 1'b0;
        e_seg   = (s_lz && d != 0 && d > hi) ? 7'h7F : glyph_tab[m_disp[4*d +: 4]];
        e_dpn   = ~m_disp_dp[d];
      end
      e_fd = (m_p % NS == 0);
      if (e_fd) begin
        if (s_load) begin
          m_disp = s_val; m_disp_dp = s_dp;
        end else if (m_pending) begin
          m_disp = m_shadow; m_disp_dp = m_shadow_dp;
        end
        m_pending = 0;
      end else if (s_load) begin
        m_pending = 1;
      end
      if (s_load) begin
        m_shadow = s_val; m_shadow_dp = s_dp;
      end
    end
    #1;
    chk($sformatf("model t=%0t {seg,dp_n,an,fd}", $time),
        {bus.seg, bus.dp_n, bus.an, bus.frame_done}, {e_seg, e_dpn, e_an, e_fd});
  endtask

  task automatic sync_fd(input string name);
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < 3 * NS) begin
      step();
      n++;
    end
    chk({name, " frame_done reached"}, bus.frame_done, 1'b1);
  endtask

  task automatic load_and_sync(input logic [15:0] v, input logic [3:0] dp, input string name);
    bus.value = v;
    bus.dp_in = dp;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    sync_fd(name);
  endtask

  task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dpn,
                               output int nfd, output int nlit);
    segs = '0; dpn = '0; nfd = 0; nlit = 0;
    for (int i = 0; i < NS; i++) begin
      step();
      if (bus.frame_done) nfd++;
      for (int k = 0; k < N; k++) begin
        if (bus.an[k] == 1'b0) begin
          segs[7*k +: 7] = bus.seg;
          dpn[k]         = bus.dp_n;
          nlit++;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    logic [27:0] segs;
    logic [3:0]  dpn;
    logic [15:0] oldv;
    int nfd, nlit, bad, n, k, last, gap_bad;

    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    tab[0] = '{16'h89AB, 4'b0100, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1011};
    tab[1] = '{16'h3210, 4'b0000, 1'b0, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111};
    tab[2] = '{16'h7654, 4'b1001, 1'b0, {7'h78, 7'h02, 7'h12, 7'h19}, 4'b0110};
    tab[3] = '{16'hBA98, 4'b0000, 1'b0, {7'h03, 7'h08, 7'h10, 7'h00}, 4'b1111};
    tab[4] = '{16'hFEDC, 4'b0010, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'b1101};
    tab[5] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    tab[6] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    tab[7] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    tab[8] = '{16'h0000, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
    tab[9] = '{16'h0500, 4'b0000, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h40}, 4'b1111};

    reset = 1'b1;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    bus.blank_lz = 1'b0; bus.blink_en = 1'b0;
    m_started = 0; m_p = 0;
    model_clear();

    // Reset and first scan.
    repeat (3) begin
      step();
      chk("reset an", bus.an, 4'hF);
      chk("reset seg", bus.seg, 7'h7F);
      chk("reset fd", bus.frame_done, 1'b0);
    end
    reset = 1'b0;
    step();
    chk("release edge1 an", bus.an, 4'hF);
    step();
    chk("release edge2 an", bus.an, 4'b1110);
    repeat (3) step();
    chk("digit0 held 4 cycles an", bus.an, 4'b1110);
    step();
    chk("digit1 an", bus.an, 4'b1101);
    nfd = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 3 * NS; i++) begin
      step();
      if (bus.frame_done) begin
        if (last >= 0 && i - last != NS) gap_bad++;
        last = i;
        nfd++;
      end
    end
    chk("frame_done count in 48 cycles", nfd, 3);
    chk("frame_done period errors", gap_bad, 0);

    // Table of glyph, dp and leading-zero vectors.
    for (int v = 0; v < 10; v++) begin
      bus.blank_lz = tab[v].lz;
      load_and_sync(tab[v].val, tab[v].dp, $sformatf("vec%0d", v));
      capture_frame(segs, dpn, nfd, nlit);
      chk($sformatf("vec%0d segs", v), segs, tab[v].segs);
      chk($sformatf("vec%0d dp_n", v), dpn, tab[v].dpn);
      chk($sformatf("vec%0d lit", v), nlit, NS);
    end
    bus.blank_lz = 1'b0;

    // Tear-free load mid-frame.
    oldv = 16'h89AB;
    load_and_sync(oldv, 4'b0000, "tear setup");
    repeat (5) step();
    bus.value = 16'h1234; bus.dp_in = 4'b0000; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bad = 0; n = 0;
    while (1) begin
      if (bus.an != 4'hF) begin
        k = 0;
        for (int j = 0; j < N; j++) if (bus.an[j] == 1'b0) k = j;
        if (bus.seg != glyph_tab[oldv[4*k +: 4]]) bad++;
      end
      if (bus.frame_done || n > 3 * NS) break;
      step();
      n++;
    end
    chk("tear old value kept", bad, 0);
    chk("tear frame_done reached", bus.frame_done, 1'b1);
    capture_frame(segs, dpn, nfd, nlit);
    chk("tear new value", segs, {7'h79, 7'h24, 7'h30, 7'h19});

    // Load on the exact wrap cycle: new value shows in the frame starting now.
    repeat (NS - 1) step();
    bus.value = 16'h5A0F; bus.dp_in = 4'b0001; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("wrap load fd", bus.frame_done, 1'b1);
    capture_frame(segs, dpn, nfd, nlit);
    chk("wrap load segs", segs, {7'h12, 7'h08, 7'h40, 7'h0E});
    chk("wrap load dp_n", dpn, 4'b1110);
    capture_frame(segs, dpn, nfd, nlit);
    chk("wrap load steady", segs, {7'h12, 7'h08, 7'h40, 7'h0E});

    // Blink with BLINK_FRAMES=2: frames 2-3 dark, 0-1 and 4-5 lit.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    bus.blink_en = 1'b1;
    step();
    for (int f = 0; f < 6; f++) begin
      capture_frame(segs, dpn, nfd, nlit);
      chk($sformatf("blink frame%0d lit", f), nlit, (f == 2 || f == 3) ? 0 : NS);
      chk($sformatf("blink frame%0d fd", f), nfd, 1);
    end
    bus.blink_en = 1'b0;

    // Reset at cycle 7 of a frame.
    load_and_sync(16'h89AB, 4'b1111, "midreset setup");
    repeat (7) step();
    reset = 1'b1;
    step();
    chk("midreset an", bus.an, 4'hF);
    chk("midreset seg", bus.seg, 7'h7F);
    chk("midreset dp_n", bus.dp_n, 1'b1);
    chk("midreset fd", bus.frame_done, 1'b0);
    reset = 1'b0;
    step();
    chk("midreset release an", bus.an, 4'hF);
    capture_frame(segs, dpn, nfd, nlit);
    chk("midreset active cleared segs", segs, {7'h40, 7'h40, 7'h40, 7'h40});
    chk("midreset active cleared dp", dpn, 4'b1111);
    chk("midreset first frame fd", nfd, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.value    = 16'($urandom);
      if ($urandom_range(0, 1) == 0) bus.value[15:8] = 8'h00;
      bus.dp_in    = 4'($urandom);
      if (i % 40 == 0) begin
        bus.blank_lz = 1'($urandom);
        bus.blink_en = 1'($urandom);
      end
      step();
    end
    reset = 1'b0;
    bus.load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
